// File: rtl/i2c_target_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | i2c_target_regfile: oversampled I2C target with pointer-addressed regfile  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module i2c_target_regfile #(
    parameter logic [6:0] DEVICE_ADDR = 7'h20,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic [8*NUM_REGS-1:0] regs_packed,
    input  logic                  host_we,
    input  logic [PTR_W-1:0]      host_idx,
    input  logic [7:0]            host_wdata,
    output logic                  wr_strobe,
    output logic [PTR_W-1:0]      wr_idx,
    output logic                  busy
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ADDR     = 4'd1,
        ST_ADDR_ACK = 4'd2,
        ST_PTR      = 4'd3,
        ST_PTR_ACK  = 4'd4,
        ST_WRITE    = 4'd5,
        ST_WR_ACK   = 4'd6,
        ST_READ     = 4'd7,
        ST_RD_ACK   = 4'd8,
        ST_IGNORE   = 4'd9
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t                 r_state;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [7:0]             r_tx;
    logic [PTR_W-1:0]       r_ptr;
    logic                   r_rw;
    logic                   r_sda_oe;
    logic                   r_busy;
    logic                   r_wr_strobe;
    logic [PTR_W-1:0]       r_wr_idx;
    logic [7:0]             r_regs [NUM_REGS];

    logic                   w_scl;
    logic                   w_sda;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_rx_byte;
    logic [7:0]             w_snap;
    logic [PTR_W-1:0]       w_ptr_next;
    logic                   w_ptr_ok;
    logic                   w_host_ok;

    // Synchronisers idle high so a released bus never looks like a START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;
    assign w_rx_byte  = {r_shift[6:0], w_sda};
    assign w_snap     = r_regs[r_ptr];
    assign w_ptr_next = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
    assign w_ptr_ok   = 32'(r_shift) < NUM_REGS;
    assign w_host_ok  = 32'(host_idx) < NUM_REGS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_idx    <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            // Host write first so a same-cycle I2C commit to the same index overrides it.
            if (host_we && w_host_ok) r_regs[host_idx] <= host_wdata;

            if (w_start) begin
                r_state   <= ST_ADDR;
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
            end else if (w_stop) begin
                r_state  <= ST_IDLE;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WRITE: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_state == ST_WRITE && r_bit_cnt == 4'd7) begin
                                r_regs[r_ptr] <= w_rx_byte;
                                r_wr_strobe   <= 1'b1;
                                r_wr_idx      <= r_ptr;
                                r_ptr         <= w_ptr_next;
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            case (r_state)
                                ST_ADDR: begin
                                    if (r_shift[7:1] == DEVICE_ADDR) begin
                                        r_sda_oe <= 1'b1;
                                        r_busy   <= 1'b1;
                                        r_rw     <= r_shift[0];
                                        r_state  <= ST_ADDR_ACK;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                    end
                                end
                                ST_PTR: begin
                                    if (w_ptr_ok) begin
                                        r_ptr    <= r_shift[PTR_W-1:0];
                                        r_sda_oe <= 1'b1;
                                        r_state  <= ST_PTR_ACK;
                                    end else begin
                                        r_state <= ST_IGNORE;
                                    end
                                end
                                default: begin
                                    r_sda_oe <= 1'b1;
                                    r_state  <= ST_WR_ACK;
                                end
                            endcase
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= '0;
                            if (r_rw) begin
                                r_tx      <= {w_snap[6:0], 1'b0};
                                r_sda_oe  <= ~w_snap[7];
                                r_bit_cnt <= 4'd1;
                                r_state   <= ST_READ;
                            end else begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_PTR;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe  <= 1'b0;
                            r_bit_cnt <= '0;
                            r_state   <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_tx      <= {w_snap[6:0], 1'b0};
                                r_sda_oe  <= ~w_snap[7];
                                r_bit_cnt <= 4'd1;
                            end else if (r_bit_cnt == 4'd8) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= ST_RD_ACK;
                            end else begin
                                r_sda_oe  <= ~r_tx[7];
                                r_tx      <= {r_tx[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // Pointer advances past every byte sent; ACK fetches the next one.
                        if (w_scl_rise) begin
                            r_ptr     <= w_ptr_next;
                            r_bit_cnt <= '0;
                            r_state   <= w_sda ? ST_IGNORE : ST_READ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs_packed[8*g +: 8] = r_regs[g];
    end

    assign sda_oe    = r_sda_oe;
    assign busy      = r_busy;
    assign wr_strobe = r_wr_strobe;
    assign wr_idx    = r_wr_idx;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_i2c_target_regfile: bus-master bench with a register-file model         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_i2c_target_regfile;

    localparam int         N    = 4;
    localparam int         PW   = 2;
    localparam logic [6:0] ADDR = 7'h20;

    logic           clock      = 1'b0;
    logic           reset      = 1'b1;
    logic           m_scl      = 1'b1;
    logic           m_sda      = 1'b1;
    logic           host_we    = 1'b0;
    logic [PW-1:0]  host_idx   = '0;
    logic [7:0]     host_wdata = '0;
    logic           w_sda_bus;
    logic           sda_oe;
    logic           wr_strobe;
    logic           busy;
    logic [PW-1:0]  wr_idx;
    logic [8*N-1:0] regs_packed;

    int             n_vec = 0;
    int             n_err = 0;
    logic [7:0]     mregs [N];
    int             mptr;

    int             oe_cnt   = 0;
    int             busy_cnt = 0;
    int             strobe_q [$];

    assign w_sda_bus = m_sda & ~sda_oe;

    i2c_target_regfile #(
        .DEVICE_ADDR (ADDR),
        .NUM_REGS    (N),
        .SYNC_STAGES (2)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .scl_in      (m_scl),
        .sda_in      (w_sda_bus),
        .sda_oe      (sda_oe),
        .regs_packed (regs_packed),
        .host_we     (host_we),
        .host_idx    (host_idx),
        .host_wdata  (host_wdata),
        .wr_strobe   (wr_strobe),
        .wr_idx      (wr_idx),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (wr_strobe) strobe_q.push_back(int'(wr_idx));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [8*N-1:0] model_packed();
        logic [8*N-1:0] v;
        for (int i = 0; i < N; i++) v[8*i +: 8] = mregs[i];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        tick(5); m_sda = b;
        tick(5); m_scl = 1'b1;
        tick(5); s = w_sda_bus;
        tick(5); m_scl = 1'b0;
    endtask

    task automatic start_cond();
        if (m_scl == 1'b0) begin
            tick(5); m_sda = 1'b1;
            tick(5); m_scl = 1'b1;
        end
        tick(5); m_sda = 1'b0;
        tick(5); m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(5); m_sda = 1'b0;
        tick(5); m_scl = 1'b1;
        tick(5); m_sda = 1'b1;
        tick(10);
    endtask

    task automatic host_wr(input logic [PW-1:0] idx, input logic [7:0] d);
        host_idx = idx; host_wdata = d; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    // Last data bit is hand-timed so host_we lands on the commit clock (2-flop sync + edge).
    task automatic write_byte_hw(input logic [7:0] d, input logic [PW-1:0] hidx,
                                 input logic [7:0] hdata, output logic ack, output logic strobe);
        logic s;
        for (int i = 7; i >= 1; i--) bus_bit(d[i], s);
        tick(5); m_sda = d[0];
        tick(5); m_scl = 1'b1;
        tick(2); host_idx = hidx; host_wdata = hdata; host_we = 1'b1;
        tick(1); host_we = 1'b0; strobe = wr_strobe;
        tick(7); m_scl = 1'b0;
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic give_ack, input logic hw_en, input logic [PW-1:0] hidx,
                             input logic [7:0] hdata, output logic [7:0] d);
        logic s;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            if (hw_en && i == 3) host_wr(hidx, hdata);
            bus_bit(1'b1, s);
            d = {d[6:0], s};
        end
        bus_bit(~give_ack, s);
    endtask

    function automatic logic [7:0] model_read();
        logic [7:0] v;
        v = mregs[mptr];
        mptr = (mptr + 1) % N;
        return v;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < N; i++) mregs[i] = '0;
        mptr = 0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL reset_sda_oe got=%b exp=0", sda_oe); end
        n_vec++; if (wr_strobe !== 1'b0) begin n_err++; $display("FAIL reset_wr_strobe got=%b exp=0", wr_strobe); end
        n_vec++; if (wr_idx !== '0) begin n_err++; $display("FAIL reset_wr_idx got=%0d exp=0", wr_idx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_vec++; if (regs_packed !== '0) begin n_err++; $display("FAIL reset_regs got=%h exp=0", regs_packed); end
    endtask

    task automatic test_write_burst();
        logic [3:0] acks;
        logic       a;
        int         base;
        base = strobe_q.size();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wb_busy_pre got=%b exp=0", busy); end
        start_cond();
        write_byte({ADDR, 1'b0}, a); acks[3] = a;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL wb_busy_mid got=%b exp=1", busy); end
        write_byte(8'h01, a); acks[2] = a;
        write_byte(8'hA5, a); acks[1] = a;
        write_byte(8'h3C, a); acks[0] = a;
        stop_cond();
        mregs[1] = 8'hA5; mregs[2] = 8'h3C; mptr = 3;
        n_vec++; if (acks !== 4'b1111) begin n_err++; $display("FAIL wb_acks got=%b exp=1111", acks); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL wb_busy_post got=%b exp=0", busy); end
        n_vec++;
        if (strobe_q.size() - base !== 2) begin
            n_err++; $display("FAIL wb_strobe_count got=%0d exp=2", strobe_q.size() - base);
        end else if (strobe_q[base] !== 1 || strobe_q[base+1] !== 2) begin
            n_err++; $display("FAIL wb_wr_idx got=%0d,%0d exp=1,2", strobe_q[base], strobe_q[base+1]);
        end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL wb_regs got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    task automatic test_wrong_addr();
        logic [2:0] acks;
        logic       a;
        int         oe0, busy0;
        oe0 = oe_cnt; busy0 = busy_cnt;
        start_cond();
        write_byte(8'h42, a); acks[2] = a;
        write_byte(8'h00, a); acks[1] = a;
        write_byte(8'hFF, a); acks[0] = a;
        stop_cond();
        n_vec++; if (acks !== 3'b000) begin n_err++; $display("FAIL wa_acks got=%b exp=000", acks); end
        n_vec++; if (oe_cnt != oe0) begin n_err++; $display("FAIL wa_sda_oe cycles got=%0d exp=0", oe_cnt - oe0); end
        n_vec++; if (busy_cnt != busy0) begin n_err++; $display("FAIL wa_busy cycles got=%0d exp=0", busy_cnt - busy0); end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL wa_regs got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    task automatic test_wrap_read();
        logic       a;
        logic [7:0] got, exp;
        for (int i = 0; i < N; i++) begin
            host_wr(PW'(i), 8'(8'h11 * (i + 1)));
            mregs[i] = 8'(8'h11 * (i + 1));
        end
        start_cond();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h03, a);
        mptr = 3;
        n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_ptr_ack got=%b exp=1", a); end
        start_cond();
        write_byte({ADDR, 1'b1}, a);
        n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL wr_raddr_ack got=%b exp=1", a); end
        for (int b = 0; b < 3; b++) begin
            read_byte(b != 2, 1'b0, '0, '0, got);
            exp = model_read();
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL wr_byte%0d got=%h exp=%h", b, got, exp); end
        end
        tick(4);
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL wr_release got=%b exp=0", sda_oe); end
        stop_cond();
        start_cond();
        write_byte({ADDR, 1'b1}, a);
        read_byte(1'b0, 1'b0, '0, '0, got);
        exp = model_read();
        stop_cond();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL wr_final_ptr got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ptr_oor();
        logic [2:0] acks;
        logic       a;
        logic [7:0] got, exp;
        int         base;
        base = strobe_q.size();
        start_cond();
        write_byte({ADDR, 1'b0}, a); acks[2] = a;
        write_byte(8'h07, a); acks[1] = a;
        write_byte(8'h99, a); acks[0] = a;
        stop_cond();
        n_vec++; if (acks !== 3'b100) begin n_err++; $display("FAIL oor_acks got=%b exp=100", acks); end
        n_vec++; if (strobe_q.size() != base) begin n_err++; $display("FAIL oor_strobe got=%0d exp=0", strobe_q.size() - base); end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL oor_regs got=%h exp=%h", regs_packed, model_packed()); end
        start_cond();
        write_byte({ADDR, 1'b1}, a);
        read_byte(1'b0, 1'b0, '0, '0, got);
        exp = model_read();
        stop_cond();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL oor_ptr_kept got=%h exp=%h", got, exp); end
    endtask

    task automatic test_conflict();
        logic a, s1, s2, a1, a2;
        start_cond();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h02, a);
        write_byte_hw(8'hAA, 2'd2, 8'h55, a1, s1);
        write_byte_hw(8'hBB, 2'd0, 8'h66, a2, s2);
        stop_cond();
        mregs[2] = 8'hAA; mregs[0] = 8'h66; mregs[3] = 8'hBB; mptr = 0;
        n_vec++; if ({a, a1, a2} !== 3'b111) begin n_err++; $display("FAIL cf_acks got=%b exp=111", {a, a1, a2}); end
        n_vec++; if ({s1, s2} !== 2'b11) begin n_err++; $display("FAIL cf_same_clock got=%b exp=11", {s1, s2}); end
        n_vec++; if (regs_packed[23:16] !== 8'hAA) begin n_err++; $display("FAIL cf_reg2 got=%h exp=aa", regs_packed[23:16]); end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL cf_regs got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    task automatic test_host_mid_read();
        logic       a;
        logic [7:0] got, exp;
        host_wr(2'd0, 8'h3C);
        mregs[0] = 8'h3C;
        start_cond();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h00, a);
        mptr = 0;
        start_cond();
        write_byte({ADDR, 1'b1}, a);
        read_byte(1'b0, 1'b1, 2'd0, 8'hC3, got);
        exp = model_read();
        mregs[0] = 8'hC3;
        stop_cond();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL hm_snapshot got=%h exp=%h", got, exp); end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL hm_regs got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    task automatic test_reset_mid_read();
        logic       s, a, a2, a3;
        logic [7:0] got, exp;
        logic [7:0] addr_r;
        addr_r = {ADDR, 1'b1};
        start_cond();
        for (int i = 7; i >= 0; i--) bus_bit(addr_r[i], s);
        tick(5); m_sda = 1'b1;
        tick(5); m_scl = 1'b1;
        tick(5);
        n_vec++; if (sda_oe !== 1'b1) begin n_err++; $display("FAIL rm_pre_oe got=%b exp=1", sda_oe); end
        #2 reset = 1'b1;
        #1;
        n_vec++; if (sda_oe !== 1'b0) begin n_err++; $display("FAIL rm_async_oe got=%b exp=0", sda_oe); end
        m_scl = 1'b1; m_sda = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(3);
        for (int i = 0; i < N; i++) mregs[i] = '0;
        mptr = 0;
        n_vec++; if (regs_packed !== '0) begin n_err++; $display("FAIL rm_regs got=%h exp=0", regs_packed); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_busy got=%b exp=0", busy); end
        host_wr(2'd0, 8'h5A);
        mregs[0] = 8'h5A;
        start_cond();
        write_byte({ADDR, 1'b1}, a);
        read_byte(1'b0, 1'b0, '0, '0, got);
        exp = model_read();
        stop_cond();
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL rm_ptr_zero got=%h exp=%h", got, exp); end
        start_cond();
        write_byte({ADDR, 1'b0}, a);
        write_byte(8'h01, a2);
        write_byte(8'h77, a3);
        stop_cond();
        mregs[1] = 8'h77; mptr = 2;
        n_vec++; if ({a, a2, a3} !== 3'b111) begin n_err++; $display("FAIL rm_write_acks got=%b exp=111", {a, a2, a3}); end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL rm_regs_post got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    task automatic test_random();
        logic       a, exp_ack;
        logic [7:0] d, got, exp;
        int         op, p, nb, hi;
        for (int it = 0; it < 14; it++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                p = $urandom_range(0, N + 1);
                nb = $urandom_range(1, 3);
                exp_ack = (p < N);
                start_cond();
                write_byte({ADDR, 1'b0}, a);
                n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL rnd_waddr it=%0d got=%b exp=1", it, a); end
                write_byte(8'(p), a);
                n_vec++; if (a !== exp_ack) begin n_err++; $display("FAIL rnd_ptr it=%0d got=%b exp=%b", it, a, exp_ack); end
                if (p < N) mptr = p;
                for (int b = 0; b < nb; b++) begin
                    d = 8'($urandom);
                    write_byte(d, a);
                    n_vec++; if (a !== exp_ack) begin n_err++; $display("FAIL rnd_data it=%0d got=%b exp=%b", it, a, exp_ack); end
                    if (p < N) begin
                        mregs[mptr] = d;
                        mptr = (mptr + 1) % N;
                    end
                end
                stop_cond();
            end else if (op == 1) begin
                nb = $urandom_range(1, 4);
                start_cond();
                write_byte({ADDR, 1'b1}, a);
                n_vec++; if (a !== 1'b1) begin n_err++; $display("FAIL rnd_raddr it=%0d got=%b exp=1", it, a); end
                for (int b = 0; b < nb; b++) begin
                    read_byte(b != nb - 1, 1'b0, '0, '0, got);
                    exp = model_read();
                    n_vec++; if (got !== exp) begin n_err++; $display("FAIL rnd_read it=%0d got=%h exp=%h", it, got, exp); end
                end
                stop_cond();
            end else begin
                hi = $urandom_range(0, N - 1);
                d = 8'($urandom);
                host_wr(PW'(hi), d);
                mregs[hi] = d;
            end
        end
        n_vec++; if (regs_packed !== model_packed()) begin n_err++; $display("FAIL rnd_regs got=%h exp=%h", regs_packed, model_packed()); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_wrong_addr();
        test_wrap_read();
        test_ptr_oor();
        test_conflict();
        test_host_mid_read();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
